// File: rtl/fp_sub_seq.sv
// rtl/fp_sub_seq.sv - multi-cycle IEEE-754 subtractor with one-bit-per-cycle renormalisation
module fp_sub_seq #(
    parameter int NEXP        = 5,
    parameter int NSIG        = 10,
    parameter int NRAS        = 4,
    parameter int NTYPES      = 6,
    parameter int NEXCEPTIONS = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NEXP+NSIG:0]       a,
    input  logic [NEXP+NSIG:0]       b,
    input  logic [NRAS:0]            ra,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NEXP+NSIG:0]       s,
    output logic [NTYPES-1:0]        sFlags,
    output logic [NEXCEPTIONS-1:0]   exception
);
    localparam int W    = NEXP + NSIG + 1;
    localparam int F    = NSIG + 3;          // fraction bits below the significand LSB
    localparam int XW   = 2 * F;             // extended significand width
    localparam int EW   = NEXP + 2;          // signed unbiased exponent width
    localparam int BIAS = (1 << (NEXP - 1)) - 1;

    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMIN_E = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] F_E    = EW'(F);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);

    // class flag, rounding attribute and exception bit positions
    localparam int C_ZERO = 0, C_SUB = 1, C_NORM = 2, C_INF = 3, C_QNAN = 4, C_SNAN = 5;
    localparam int R_RNE = 0, R_RNA = 1, R_RTZ = 2, R_RTP = 3, R_RTN = 4;
    localparam int X_INVALID = 0, X_OVERFLOW = 2, X_INEXACT = 4;

    typedef enum logic [2:0] {IDLE, CALC, NORM, ROUND, DONE} state_t;

    state_t                  state_q, state_d;
    logic [W-1:0]            a_q, a_d, b_q, b_d;
    logic [NRAS:0]           ra_q, ra_d;
    logic                    sign_q, sign_d;
    logic signed [EW-1:0]    exp_q, exp_d;
    logic [XW-1:0]           sig_q, sig_d;
    logic [W-1:0]            s_q, s_d;
    logic [NTYPES-1:0]       flags_q, flags_d;
    logic [NEXCEPTIONS-1:0]  exc_q, exc_d;
    logic                    out_valid_q, out_valid_d;

    function automatic logic [NTYPES-1:0] classify(input logic [W-2:0] x);
        logic [NTYPES-1:0] c;
        c = '0;
        if (&x[W-2:NSIG]) begin
            if (x[NSIG-1:0] == '0)  c[C_INF]  = 1'b1;
            else if (x[NSIG-1])     c[C_QNAN] = 1'b1;
            else                    c[C_SNAN] = 1'b1;
        end else if (x[W-2:NSIG] == '0) begin
            if (x[NSIG-1:0] == '0)  c[C_ZERO] = 1'b1;
            else                    c[C_SUB]  = 1'b1;
        end else begin
            c[C_NORM] = 1'b1;
        end
        return c;
    endfunction

    // subnormals share the EMIN exponent with a zero hidden bit
    function automatic logic signed [EW-1:0] unb_exp(input logic [NEXP-1:0] e);
        if (e == '0) return EMIN_E;
        return $signed({2'b00, e}) - BIAS_E;
    endfunction

    logic [NTYPES-1:0]    fa, fb;
    logic signed [EW-1:0] ea, eb, dexp, ecalc;
    logic [NSIG:0]        ma, mb;
    logic [EW-1:0]        shamt;
    logic                 a_ge, eff_sub, neg, carry, rsign;
    logic [XW-1:0]        xa, xb, mag0, mag;
    logic [XW:0]          diff;

    // operand decode, alignment and magnitude add/subtract on the registered operands
    always_comb begin
        fa      = classify(a_q[W-2:0]);
        fb      = classify(b_q[W-2:0]);
        ea      = unb_exp(a_q[W-2:NSIG]);
        eb      = unb_exp(b_q[W-2:NSIG]);
        ma      = {|a_q[W-2:NSIG], a_q[NSIG-1:0]};
        mb      = {|b_q[W-2:NSIG], b_q[NSIG-1:0]};
        a_ge    = (ea >= eb);
        dexp    = a_ge ? (ea - eb) : (eb - ea);
        shamt   = (dexp > F_E) ? F_E : dexp;
        xa      = {2'b00, ma, {F{1'b0}}} >> (a_ge ? '0 : shamt);
        xb      = {2'b00, mb, {F{1'b0}}} >> (a_ge ? shamt : '0);
        // a - b is a magnitude subtraction when the raw signs agree
        eff_sub = (a_q[W-1] == b_q[W-1]);
        diff    = eff_sub ? ({1'b0, xa} - {1'b0, xb}) : ({1'b0, xa} + {1'b0, xb});
        neg     = eff_sub & diff[XW];
        mag0    = neg ? (~diff[XW-1:0] + XW'(1)) : diff[XW-1:0];
        carry   = mag0[F+NSIG+1];
        mag     = carry ? ((mag0 >> 1) | {{(XW-1){1'b0}}, mag0[0]}) : mag0;
        ecalc   = (a_ge ? ea : eb) + (carry ? ONE_E : '0);
        rsign   = a_q[W-1] ^ neg;
    end

    logic [NSIG:0]           keep, rsig;
    logic [NSIG+1:0]         rsum;
    logic                    g, st, up, to_max;
    logic signed [EW-1:0]    er;
    logic [W-1:0]            rres;
    logic [NTYPES-1:0]       rflags;
    logic [NEXCEPTIONS-1:0]  rexc;

    // rounding of sig[NSIG:-NSIG-3] and result packing
    always_comb begin
        keep   = sig_q[F+NSIG:F];
        g      = sig_q[F-1];
        st     = |sig_q[F-2:0];
        up     = (ra_q[R_RNE] & g & (st | keep[0])) | (ra_q[R_RNA] & g) |
                 (ra_q[R_RTP] & ~sign_q & (g | st)) | (ra_q[R_RTN] & sign_q & (g | st));
        rsum   = {1'b0, keep} + {{(NSIG+1){1'b0}}, up};
        rsig   = rsum[NSIG+1] ? rsum[NSIG+1:1] : rsum[NSIG:0];
        er     = exp_q + (rsum[NSIG+1] ? ONE_E : '0);
        to_max = ra_q[R_RTZ] | (ra_q[R_RTN] & ~sign_q) | (ra_q[R_RTP] & sign_q);
        rres   = '0;
        rflags = '0;
        rexc   = '0;
        rexc[X_INEXACT] = g | st;
        if (er > BIAS_E) begin
            rexc[X_OVERFLOW] = 1'b1;
            rexc[X_INEXACT]  = 1'b1;
            if (to_max) begin
                rres = {sign_q, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
                rflags[C_NORM] = 1'b1;
            end else begin
                rres = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
                rflags[C_INF] = 1'b1;
            end
        end else if (!rsig[NSIG]) begin
            rres = {sign_q, {NEXP{1'b0}}, rsig[NSIG-1:0]};
            if (rsig == '0) rflags[C_ZERO] = 1'b1;
            else            rflags[C_SUB]  = 1'b1;
        end else begin
            rres = {sign_q, NEXP'(er + BIAS_E), rsig[NSIG-1:0]};
            rflags[C_NORM] = 1'b1;
        end
    end

    // next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ra_d    = ra_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        s_d     = s_q;
        flags_d = flags_q;
        exc_d   = exc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    ra_d    = ra;
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = DONE;
                flags_d = '0;
                exc_d   = '0;
                if (fa[C_SNAN] || (!fb[C_SNAN] && fa[C_QNAN])) begin
                    s_d     = a_q;
                    flags_d = fa;
                end else if (fb[C_SNAN] || fb[C_QNAN]) begin
                    s_d     = b_q;
                    flags_d = fb;
                end else if (fa[C_INF] && fb[C_INF] && eff_sub) begin
                    s_d              = {a_q[W-1], {NEXP{1'b1}}, {NSIG{1'b1}}};
                    flags_d[C_QNAN]  = 1'b1;
                    exc_d[X_INVALID] = 1'b1;
                end else if (fa[C_INF] || fb[C_ZERO] && !fa[C_ZERO]) begin
                    s_d     = a_q;
                    flags_d = fa;
                end else if (fb[C_INF] || fa[C_ZERO] && !fb[C_ZERO]) begin
                    s_d     = {~b_q[W-1], b_q[W-2:0]};
                    flags_d = fb;
                end else if (fa[C_ZERO] || mag == '0) begin
                    s_d             = {(fa[C_ZERO] && !eff_sub) ? a_q[W-1] : ra_q[R_RTN], {(W-1){1'b0}}};
                    flags_d[C_ZERO] = 1'b1;
                end else begin
                    sign_d  = rsign;
                    exp_d   = ecalc;
                    sig_d   = mag;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (sig_q[F+NSIG] || exp_q == EMIN_E) begin
                    state_d = ROUND;
                end else begin
                    sig_d = sig_q << 1;
                    exp_d = exp_q - ONE_E;
                end
            end
            ROUND: begin
                s_d     = rres;
                flags_d = rflags;
                exc_d   = rexc;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
    end

    // state and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ra_q        <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            sig_q       <= '0;
            s_q         <= '0;
            flags_q     <= '0;
            exc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ra_q        <= ra_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            sig_q       <= sig_d;
            s_q         <= s_d;
            flags_q     <= flags_d;
            exc_q       <= exc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign sFlags    = flags_q;
    assign exception = exc_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// tb/tb_fp_sub_seq.sv - directed-vector bench for fp_sub_seq
module tb_fp_sub_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0, b = '0;
    logic [4:0]  ra = 5'b00001;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] s;
    logic [5:0]  sFlags;
    logic [4:0]  exception;

    localparam logic [4:0] RNE = 5'b00001, RTZ = 5'b00100, RTN = 5'b10000;
    localparam logic [5:0] F_ZERO = 6'h01, F_SUB = 6'h02, F_NORM = 6'h04, F_INF = 6'h08, F_QNAN = 6'h10;
    localparam logic [4:0] E_NONE = 5'h00, E_INV = 5'h01, E_OVF_INX = 5'h14, E_INX = 5'h10;

    int n_checks = 0;
    int n_pass = 0;

    fp_sub_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ra(ra), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .sFlags(sFlags), .exception(exception)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic accept(input logic [15:0] ai, input logic [15:0] bi, input logic [4:0] rai);
        int guard = 0;
        while (!in_ready && guard < 64) begin @(posedge clk); #1; guard++; end
        a = ai; b = bi; ra = rai; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        ra = rai[2] ? RNE : RTZ;
    endtask

    // elat of 0 skips the latency comparison and only requires the result to appear
    task automatic run_op(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                          input logic [4:0] rai, input logic [15:0] es, input logic [5:0] ef,
                          input logic [4:0] ee, input int elat);
        int lat = 1;
        accept(ai, bi, rai);
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        if (elat > 0) check({tag, " latency"}, lat, elat);
        else          check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " s"}, {16'd0, s}, {16'd0, es});
        check({tag, " flags"}, {26'd0, sFlags}, {26'd0, ef});
        check({tag, " exc"}, {27'd0, exception}, {27'd0, ee});
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        int guard;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset s", {16'd0, s}, 32'd0);
        check("reset flags", {26'd0, sFlags}, 32'd0);
        check("reset exc", {27'd0, exception}, 32'd0);
        rst_n = 1'b1;

        run_op("1-0.5",        16'h3C00, 16'h3800, RNE, 16'h3800, F_NORM, E_NONE,    5);
        run_op("1-1 rne",      16'h3C00, 16'h3C00, RNE, 16'h0000, F_ZERO, E_NONE,    2);
        run_op("1-1 rtn",      16'h3C00, 16'h3C00, RTN, 16'h8000, F_ZERO, E_NONE,    2);
        run_op("0-(-0) rtn",   16'h0000, 16'h8000, RTN, 16'h0000, F_ZERO, E_NONE,    2);
        run_op("inf-inf",      16'h7C00, 16'h7C00, RNE, 16'h7FFF, F_QNAN, E_INV,     2);
        run_op("inf-(-inf)",   16'h7C00, 16'hFC00, RNE, 16'h7C00, F_INF,  E_NONE,    2);
        run_op("1-inf",        16'h3C00, 16'h7C00, RNE, 16'hFC00, F_INF,  E_NONE,    2);
        run_op("0-1",          16'h0000, 16'h3C00, RNE, 16'hBC00, F_NORM, E_NONE,    2);
        run_op("ovf rne",      16'h7BFF, 16'hFBFF, RNE, 16'h7C00, F_INF,  E_OVF_INX, 4);
        run_op("ovf rtz",      16'h7BFF, 16'hFBFF, RTZ, 16'h7BFF, F_NORM, E_OVF_INX, 4);
        run_op("cancel",       16'h3C00, 16'h3BFF, RNE, 16'h1000, F_NORM, E_NONE,    0);
        run_op("subnormal",    16'h0401, 16'h0400, RNE, 16'h0001, F_SUB,  E_NONE,    4);
        run_op("sat rne",      16'h3C00, 16'h0001, RNE, 16'h3C00, F_NORM, E_INX,     5);
        run_op("sat rtz",      16'h3C00, 16'h0001, RTZ, 16'h3BFF, F_NORM, E_INX,     5);

        out_ready = 1'b0;
        accept(16'h3C00, 16'h3800, RNE);
        guard = 0;
        while (!out_valid && guard < 64) begin @(posedge clk); #1; guard++; end
        check("bp valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp hold valid", {31'd0, out_valid}, 32'd1);
            check("bp hold s", {16'd0, s}, 32'h3800);
            check("bp hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        check("bp release valid", {31'd0, out_valid}, 32'd0);

        accept(16'h3C00, 16'h3BFF, RNE);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst norm valid", {31'd0, out_valid}, 32'd0);
        check("rst norm in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
        check("rst norm no stale", seen, 0);

        out_ready = 1'b0;
        accept(16'h7C00, 16'hFC00, RNE);
        guard = 0;
        while (!out_valid && guard < 64) begin @(posedge clk); #1; guard++; end
        check("rst done valid before", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst done valid", {31'd0, out_valid}, 32'd0);
        check("rst done s", {16'd0, s}, 32'd0);
        check("rst done in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (out_valid) seen++; end
        check("rst done no stale", seen, 0);

        run_op("after reset",  16'h3C00, 16'h3800, RNE, 16'h3800, F_NORM, E_NONE,    5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
